// File: rtl/online_result_collector_if.sv
// ---------------------------------------------------------------------------
// online_result_collector_if
//
// Purpose:
//   Groups the product-digit input and the parallel-result output of the
//   online result collector into one bundle.
//
// Signals:
//   start   frame start, high in the cycle the first operand digit enters
//   z_in    signed product digit (01=+1, 00=0, 11=-1, 10 illegal)
//   busy    a frame is in progress
//   done    one-cycle pulse, result valid
//   result  two's-complement product scaled by 2^no_of_digits
//   err     sticky digit error flag for the current/last frame
//
// Modports:
//   master  the producer side (drives start/z_in, observes outputs)
//   slave   the collector side
// ---------------------------------------------------------------------------
interface online_result_collector_if #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 2
);
  logic                    start;
  logic [radix_bits-1:0]   z_in;
  logic                    busy;
  logic                    done;
  logic [no_of_digits:0]   result;
  logic                    err;

  modport master (
    output start, z_in,
    input  busy, done, result, err
  );

  modport slave (
    input  start, z_in,
    output busy, done, result, err
  );
endinterface

// File: rtl/online_result_collector.sv
// ---------------------------------------------------------------------------
// online_result_collector
//
// Purpose:
//   Back end of the radix-2 online multiplier. Drops the first delta digits
//   of the MSD-first product stream, then converts the next no_of_digits
//   signed digits on the fly (Q/QM registers) into a two's-complement
//   integer equal to the product value * 2^no_of_digits, and presents it
//   with a one-cycle done pulse.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-high reset, has priority over everything
//   bus    online_result_collector_if.slave:
//            start, z_in        -> inputs
//            busy, done, result, err -> outputs
//
// Timing (start in cycle 0): done is high in cycle delta+no_of_digits.
// ---------------------------------------------------------------------------
module online_result_collector #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 2,
  parameter int radix        = 2,
  parameter int delta        = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  online_result_collector_if.slave    bus
);

  localparam int W            = no_of_digits + 1;
  localparam int K_W          = (delta + no_of_digits > 1) ? $clog2(delta + no_of_digits + 1) : 1;
  localparam int SKIP_LAST    = (delta > 0) ? delta - 1 : 0;
  localparam int COLLECT_LAST = delta + no_of_digits - 1;

  // Only the radix-2 digit set {-1,0,+1} is implemented.
  if (radix != 2) begin : g_radix_check
    $error("online_result_collector supports radix 2 only");
  end

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    COLLECT,
    DONE
  } state_t;

  state_t                state, state_next;
  logic signed [W-1:0]   q, q_next;
  logic signed [W-1:0]   qm, qm_next;
  logic signed [W-1:0]   result_r, result_next;
  logic [K_W-1:0]        k, k_next;
  logic                  err_r, err_next;

  logic                  dig_pos, dig_neg, dig_nonzero, dig_bad;
  logic signed [W-1:0]   q_base, qm_base;
  logic signed [W-1:0]   step_q, step_qm;

  // Digit decode; the illegal code is converted as zero but flagged.
  assign dig_pos     = (bus.z_in == radix_bits'(1));
  assign dig_neg     = (bus.z_in == {radix_bits{1'b1}});
  assign dig_nonzero = (bus.z_in != '0);
  assign dig_bad     = dig_nonzero && !dig_pos && !dig_neg;

  // One on-the-fly conversion step. When a frame is being accepted the
  // step starts from Q=0 / QM=-1 rather than the stale registers, so a
  // delta=0 build can convert z_1 in the start edge.
  always_comb begin
    q_base  = q;
    qm_base = qm;
    if (state == IDLE) begin
      q_base  = '0;
      qm_base = '1;
    end

    step_q  = {q_base[W-2:0], 1'b0};
    step_qm = {qm_base[W-2:0], 1'b1};
    if (dig_pos) begin
      step_q  = {q_base[W-2:0], 1'b1};
      step_qm = {q_base[W-2:0], 1'b0};
    end else if (dig_neg) begin
      step_q  = {qm_base[W-2:0], 1'b1};
      step_qm = {qm_base[W-2:0], 1'b0};
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next  = state;
    q_next      = q;
    qm_next     = qm;
    k_next      = k;
    result_next = result_r;
    err_next    = err_r;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          k_next = K_W'(1);
          if (delta == 0) begin
            q_next   = step_q;
            qm_next  = step_qm;
            err_next = dig_bad;
            if (no_of_digits == 1) begin
              result_next = step_q;
              state_next  = DONE;
            end else begin
              state_next  = COLLECT;
            end
          end else begin
            // First discarded digit: any nonzero value is an error.
            q_next     = '0;
            qm_next    = '1;
            err_next   = dig_nonzero;
            state_next = (delta > 1) ? SKIP : COLLECT;
          end
        end
      end

      SKIP: begin
        k_next = k + K_W'(1);
        if (dig_nonzero) begin
          err_next = 1'b1;
        end
        if (k == K_W'(SKIP_LAST)) begin
          state_next = COLLECT;
        end
      end

      COLLECT: begin
        k_next  = k + K_W'(1);
        q_next  = step_q;
        qm_next = step_qm;
        if (dig_bad) begin
          err_next = 1'b1;
        end
        if (k == K_W'(COLLECT_LAST)) begin
          result_next = step_q;
          state_next  = DONE;
        end
      end

      DONE: begin
        k_next     = '0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q        <= '0;
      qm       <= '1;
      k        <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      state    <= state_next;
      q        <= q_next;
      qm       <= qm_next;
      k        <= k_next;
      result_r <= result_next;
      err_r    <= err_next;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_r;
  assign bus.err    = err_r;

endmodule
